csync_separator: RTL and testbench
==================================

CSYNC_SEPARATOR -- requirements
Module: csync_separator

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 8: width of the run-length and pulse counters.
REQ-002 SHALL have parameter HPULSE_LEN, default 16: regenerated hsync low width, in clk cycles.
REQ-003 SHALL have parameter VTHRESH, default 96: low-run length, in cycles, that marks a vertical sync.
REQ-004 SHALL have parameter VEND, default 160: high-run length, in cycles, that ends a vertical sync.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port csync, input, 1 bit: composite sync, active-low, asynchronous to clk.
REQ-008 SHALL have port hsync, output, 1 bit: regenerated horizontal sync, active-low, registered.
REQ-009 SHALL have port vsync, output, 1 bit: recovered vertical sync, active-low, registered.

Function
REQ-010 SHALL synchronize csync through two flops, then keep one more flop (prev) for edge detection; fall = prev & ~sync; rise = ~prev & sync.
REQ-011 SHALL drop hsync low at the 3rd rising clk edge, counting the first edge that samples csync low.
REQ-012 SHALL hold hsync low for exactly HPULSE_LEN cycles, then drive it high, independent of the csync low width.
REQ-013 SHALL restart a full HPULSE_LEN pulse when a fall occurs while hsync is already low; the pulse is extended, not ended.
REQ-014 SHALL keep run counter runcnt (CNT_WIDTH bits): it loads 0 on the cycle of a fall or rise, increments otherwise, and saturates at 2^CNT_WIDTH-1 with no wrap.
REQ-015 SHALL implement an FSM with states V_IDLE (vsync=1) and V_SYNC (vsync=0).
REQ-016 SHALL go V_IDLE->V_SYNC when the synchronized level is low and runcnt reaches VTHRESH-1; vsync falls exactly VTHRESH cycles after hsync falls for the same low period.
REQ-017 SHALL go V_SYNC->V_IDLE when the synchronized level is high and runcnt reaches VEND-1.
REQ-018 SHALL ignore falls for FSM purposes; hsync pulses continue to be generated during V_SYNC.
REQ-019 SHALL give REQ-012/013 priority if a fall and a threshold match coincide in one cycle; both updates take effect on that edge.
REQ-020 SHALL require HPULSE_LEN, VTHRESH, VEND < 2^CNT_WIDTH and HPULSE_LEN < VTHRESH; violation is a parameter error at elaboration.

Reset
REQ-021 SHALL, while rst_n is low, asynchronously force: sync flops and prev = 1, runcnt = 0, pulse counter = 0, hsync = 1, vsync = 1, FSM = V_IDLE.
REQ-022 SHALL abort any hsync pulse or vertical interval on reset mid-operation, with no output glitch after release.
REQ-023 SHALL, after rst_n rises, detect nothing until the first genuine fall.

Configuration
REQ-024 SHALL, with CSYNC_SEP_LINE_CNT_EN defined, add output port line_cnt (9 bits, reset 0).
REQ-025 SHALL, with CSYNC_SEP_LINE_CNT_EN defined, increment line_cnt on each fall while in V_IDLE, saturating at 511.
REQ-026 SHALL, with CSYNC_SEP_LINE_CNT_EN defined, clear line_cnt to 0 on the V_IDLE->V_SYNC transition.
REQ-027 SHALL, without CSYNC_SEP_LINE_CNT_EN, have no line_cnt port and no line-counter logic.

Structure
REQ-028 SHALL take default parameter constants and typedef vsep_state_t {V_IDLE, V_SYNC} from shared package csync_pkg.
REQ-029 SHALL instantiate the two-flop synchronizer as sub-module sync_ff2 (reset value 1), reusable elsewhere.

Verification
REQ-030 SHALL cover reset: rst_n=0 with csync toggling -> hsync=1, vsync=1, line_cnt=0.
REQ-031 SHALL cover a normal line: csync low 20, then high 200 -> hsync low for exactly 16 cycles starting at the 3rd sampling edge; vsync stays 1; line_cnt=1.
REQ-032 SHALL cover retrigger: csync low 4, high 4, low 4 -> hsync stays low continuously until 16 cycles after the second detected fall; line_cnt +2.
REQ-033 SHALL cover a vertical interval: 3 repetitions of (low 120, high 40), then high 300 -> vsync falls 96 cycles after the first hsync fall; vsync stays low through the 40-cycle highs; vsync rises 160 cycles after the final detected rise; line_cnt cleared at entry.
REQ-034 SHALL cover saturation: csync held low 1000 cycles -> one hsync pulse only, vsync low from cycle 96 and held, runcnt at 255 with no wrap.
REQ-035 SHALL cover reset in V_SYNC: rst_n pulsed low mid-interval -> hsync=1 and vsync=1 immediately, without waiting for clk; FSM is V_IDLE after release.

Source files
------------

// File: rtl/csync_pkg.sv
// Shared constants and state type for the composite-sync separator.
package csync_pkg;

    localparam int DEF_CNT_WIDTH  = 8;
    localparam int DEF_HPULSE_LEN = 16;
    localparam int DEF_VTHRESH    = 96;
    localparam int DEF_VEND       = 160;
    localparam int LINE_CNT_WIDTH = 9;

    typedef enum logic {
        V_IDLE = 1'b0,
        V_SYNC = 1'b1
    } vsep_state_t;

endpackage

// File: rtl/sync_ff2.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable reset value.
module sync_ff2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/csync_separator.sv
// Splits active-low composite sync into a fixed-width hsync and a run-length-detected vsync.
// Optional line counter output is enabled with `define CSYNC_SEP_LINE_CNT_EN.
module csync_separator
    import csync_pkg::*;
#(
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int HPULSE_LEN = DEF_HPULSE_LEN,
    parameter int VTHRESH    = DEF_VTHRESH,
    parameter int VEND       = DEF_VEND
) (
    input  logic clk,
    input  logic rst_n,
    input  logic csync,
    output logic hsync,
    output logic vsync
`ifdef CSYNC_SEP_LINE_CNT_EN
    ,
    output logic [LINE_CNT_WIDTH-1:0] line_cnt
`endif
);

    if ((HPULSE_LEN < 1) || (HPULSE_LEN >= 2**CNT_WIDTH) || (VTHRESH >= 2**CNT_WIDTH) ||
        (VEND >= 2**CNT_WIDTH) || (HPULSE_LEN >= VTHRESH)) begin : g_param_err
        $error("csync_separator: illegal HPULSE_LEN/VTHRESH/VEND for CNT_WIDTH");
    end

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] HP_M1   = CNT_WIDTH'(HPULSE_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] VTH_M1  = CNT_WIDTH'(VTHRESH - 1);
    localparam logic [CNT_WIDTH-1:0] VEND_M1 = CNT_WIDTH'(VEND - 1);

    logic                 sync_lvl;
    logic                 prev;
    logic                 fall;
    logic                 rise;
    logic [CNT_WIDTH-1:0] runcnt;
    logic [CNT_WIDTH-1:0] pcnt;
    vsep_state_t          state;
    vsep_state_t          state_nxt;

    sync_ff2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (csync),
        .q     (sync_lvl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b1;
        else        prev <= sync_lvl;
    end

    assign fall = prev & ~sync_lvl;
    assign rise = ~prev & sync_lvl;

    // A fall always (re)loads a full pulse, so back-to-back falls stretch hsync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync <= 1'b1;
            pcnt  <= '0;
        end else if (fall) begin
            hsync <= 1'b0;
            pcnt  <= HP_M1;
        end else if (!hsync) begin
            if (pcnt == '0) hsync <= 1'b1;
            else            pcnt  <= pcnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                runcnt <= '0;
        else if (fall || rise)     runcnt <= '0;
        else if (runcnt != CNT_MAX) runcnt <= runcnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= V_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            V_IDLE: if (!sync_lvl && (runcnt == VTH_M1)) state_nxt = V_SYNC;
            V_SYNC: if (sync_lvl && (runcnt == VEND_M1)) state_nxt = V_IDLE;
            default: state_nxt = V_IDLE;
        endcase
    end

    always_comb begin
        vsync = (state != V_SYNC);
    end

`ifdef CSYNC_SEP_LINE_CNT_EN
    logic enter_vsync;
    assign enter_vsync = (state == V_IDLE) && (state_nxt == V_SYNC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            line_cnt <= '0;
        else if (enter_vsync)
            line_cnt <= '0;
        else if (fall && (state == V_IDLE) && (line_cnt != '1))
            line_cnt <= line_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_csync_separator.sv
// Bench for csync_separator: directed segments plus random lines against a run-length reference model.
module tb_csync_separator;
    import csync_pkg::*;

    localparam int HP   = 16;
    localparam int VT   = 96;
    localparam int VE   = 160;
    localparam int CMAX = 255;

    logic clk = 1'b0;
    logic rst_n;
    logic csync;
    logic hsync;
    logic vsync;
`ifdef CSYNC_SEP_LINE_CNT_EN
    logic [8:0] line_cnt;
`endif

    always #5 clk = ~clk;

    csync_separator dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .csync    (csync),
        .hsync    (hsync),
        .vsync    (vsync)
`ifdef CSYNC_SEP_LINE_CNT_EN
        ,
        .line_cnt (line_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: csync sample history, edge index since reset, start of current level run.
    bit samp_q[$];
    int n;
    int run_start;
    int last_drop;
    bit v_exp;
    int line_exp;
    int hs_low_cnt;
    int vs_low_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        samp_q     = '{1'b1, 1'b1, 1'b1, 1'b1};
        n          = 0;
        run_start  = 0;
        last_drop  = -100000;
        v_exp      = 1'b1;
        line_exp   = 0;
    endtask

    task automatic model_step(input bit v);
        bit lvl;
        bit lvl_before;
        bit fall;
        bit rise;
        int rc_prev;
        n++;
        samp_q.push_front(v);
        void'(samp_q.pop_back());
        // The separator acts on what it sampled two edges ago; the edge before that is the old level.
        lvl        = samp_q[2];
        lvl_before = samp_q[3];
        fall       = lvl_before && !lvl;
        rise       = !lvl_before && lvl;
        rc_prev    = (n - 1 - run_start > CMAX) ? CMAX : (n - 1 - run_start);
        if (fall) last_drop = n;
        if (v_exp && !lvl && rc_prev == VT - 1) begin
            v_exp    = 1'b0;
            line_exp = 0;
        end else if (!v_exp && lvl && rc_prev == VE - 1) begin
            v_exp = 1'b1;
        end else if (fall && v_exp && line_exp < 511) begin
            line_exp++;
        end
        if (fall || rise) run_start = n;
    endtask

    task automatic cyc(input bit v);
        int rc_exp;
        csync = v;
        @(posedge clk);
        #1;
        model_step(v);
        rc_exp = (n - run_start > CMAX) ? CMAX : (n - run_start);
        check("hsync", hsync, (n - last_drop < HP) ? 0 : 1);
        check("vsync", vsync, v_exp);
        check("runcnt", dut.runcnt, rc_exp);
`ifdef CSYNC_SEP_LINE_CNT_EN
        check("line_cnt", line_cnt, line_exp);
`endif
        if (!hsync) hs_low_cnt++;
        if (!vsync) vs_low_cnt++;
    endtask

    task automatic seg(input bit v, input int len);
        repeat (len) cyc(v);
    endtask

    // Called #1 after a clock edge; asserts reset mid-cycle and checks the outputs before any edge.
    task automatic do_reset(input int cycles);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_hsync", hsync, 1);
        check("rst_async_vsync", vsync, 1);
        repeat (cycles) begin
            csync = 1'($urandom);
            @(posedge clk);
            #1;
            check("rst_hsync", hsync, 1);
            check("rst_vsync", vsync, 1);
`ifdef CSYNC_SEP_LINE_CNT_EN
            check("rst_line_cnt", line_cnt, 0);
`endif
        end
        csync = 1'b1;
        rst_n = 1'b1;
        model_reset();
        check("rst_state", dut.state, V_IDLE);
    endtask

    initial begin
        rst_n = 1'b0;
        csync = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        do_reset(8);
        seg(1'b1, 10);

        // Normal line
        hs_low_cnt = 0;
        vs_low_cnt = 0;
        seg(1'b0, 20);
        seg(1'b1, 200);
        check("line_hs_low", hs_low_cnt, 16);
        check("line_vs_low", vs_low_cnt, 0);
`ifdef CSYNC_SEP_LINE_CNT_EN
        check("line_cnt_one", line_cnt, 1);
`endif

        // Retrigger while hsync is low
        hs_low_cnt = 0;
        seg(1'b0, 4);
        seg(1'b1, 4);
        seg(1'b0, 4);
        seg(1'b1, 100);
        check("retrig_hs_low", hs_low_cnt, 24);
`ifdef CSYNC_SEP_LINE_CNT_EN
        check("retrig_line_cnt", line_cnt, 3);
`endif

        // Vertical interval
        vs_low_cnt = 0;
        repeat (3) begin
            seg(1'b0, 120);
            seg(1'b1, 40);
        end
        seg(1'b1, 300);
        check("vert_vs_low", vs_low_cnt, 504);

        // Saturation under a long low
        hs_low_cnt = 0;
        vs_low_cnt = 0;
        seg(1'b0, 1000);
        check("sat_runcnt", dut.runcnt, 255);
        check("sat_hs_low", hs_low_cnt, 16);
        check("sat_vs_low", vs_low_cnt, 1000 - 2 - 96);
        seg(1'b1, 200);

        // Reset in the middle of a vertical interval
        seg(1'b0, 150);
        check("vsync_before_rst", vsync, 0);
        do_reset(5);
        seg(1'b1, 20);

        // Random lines
        for (int i = 0; i < 30; i++) begin
            seg(1'b0, $urandom_range(1, 140));
            seg(1'b1, $urandom_range(1, 220));
        end
        seg(1'b1, 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
